// File: rtl/price_config_pkg.sv
// Shared types and constants for the price configurator: state encoding,
// display codes, field indices and the BCD digit type.
package price_config_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIELD = 2'd1,
      ST_EDIT  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIG_BLANK = 4'd11;
   localparam bcd_t DIG_E     = 4'd12;

   localparam logic [2:0] F_SPIN   = 3'd0;
   localparam logic [2:0] F_SMALL  = 3'd1;
   localparam logic [2:0] F_MEDIUM = 3'd2;
   localparam logic [2:0] F_LARGE  = 3'd3;
   localparam logic [2:0] F_FINE   = 3'd4;

endpackage

// File: rtl/price_config_bcd_digit_step.sv
// Single BCD digit plus or minus one, wrapping 9<->0 with no carry out.
module bcd_digit_step
   import price_config_pkg::*;
(
   input  bcd_t digit,
   input  logic up,
   output bcd_t result
);

   always_comb begin
      if (up) result = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else    result = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
   end

endmodule

// File: rtl/price_config.sv
// Operator price configurator: five committed BCD tariffs edited through a
// field/digit menu driven by debounced button pulses, with 4-digit feedback.
module price_config
   import price_config_pkg::*;
#(
   parameter int          CLK_HZ    = 100_000_000,
   parameter int          BLINK_CYC = 50_000_000,
   parameter int          TIMEOUT_S = 10,
   parameter logic [11:0] DEF0      = 12'h023,
   parameter logic [11:0] DEF1      = 12'h045,
   parameter logic [11:0] DEF2      = 12'h067,
   parameter logic [11:0] DEF3      = 12'h089,
   parameter logic [11:0] DEFF      = 12'h028
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_en,
   input  logic        m_pos,
   input  logic        u_pos,
   input  logic        d_pos,
   output logic [11:0] set0,
   output logic [11:0] set1,
   output logic [11:0] set2,
   output logic [11:0] set3,
   output logic [11:0] setfine,
   output logic [3:0]  disp3,
   output logic [3:0]  disp2,
   output logic [3:0]  disp1,
   output logic [3:0]  disp0,
   output logic        cfg_busy,
   output logic        cfg_done
);

   state_t      state, state_nx;
   logic [2:0]  field, field_nx;
   logic [1:0]  digit, digit_nx;
   logic [11:0] work, work_nx;
   logic        lockout, lock_nx;
   logic        commit;
   logic [11:0] cur_price;
   bcd_t        sel_digit, stepped;
   logic [31:0] sec_cnt, idle_cnt, blink_cnt;
   logic        blink_off;
   logic        any_pulse, timeout;

   assign any_pulse = m_pos | u_pos | d_pos;
   assign timeout   = (idle_cnt >= 32'(TIMEOUT_S));
   assign cfg_busy  = (state != ST_IDLE);

   always_comb begin
      case (field)
         F_SPIN:   cur_price = set0;
         F_SMALL:  cur_price = set1;
         F_MEDIUM: cur_price = set2;
         F_LARGE:  cur_price = set3;
         F_FINE:   cur_price = setfine;
         default:  cur_price = set0;
      endcase
      case (digit)
         2'd2:    sel_digit = work[11:8];
         2'd1:    sel_digit = work[7:4];
         default: sel_digit = work[3:0];
      endcase
   end

   bcd_digit_step u_step (
      .digit  (sel_digit),
      .up     (u_pos),
      .result (stepped)
   );

   // Exit (switch off or timeout) outranks every button; among buttons m > u > d.
   always_comb begin
      state_nx = state;
      field_nx = field;
      digit_nx = digit;
      work_nx  = work;
      lock_nx  = lockout & cfg_en;
      commit   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_en && !lockout) begin
               state_nx = ST_FIELD;
               field_nx = F_SPIN;
            end
         end
         ST_FIELD, ST_EDIT: begin
            if (!cfg_en || timeout) begin
               state_nx = ST_IDLE;
               work_nx  = '0;
               digit_nx = 2'd2;
               lock_nx  = cfg_en;
            end else if (state == ST_FIELD) begin
               if (m_pos) begin
                  work_nx  = cur_price;
                  digit_nx = 2'd2;
                  state_nx = ST_EDIT;
               end else if (u_pos) begin
                  field_nx = (field == F_FINE) ? F_SPIN : field + 3'd1;
               end else if (d_pos) begin
                  field_nx = (field == F_SPIN) ? F_FINE : field - 3'd1;
               end
            end else begin
               if (m_pos) begin
                  if (digit == 2'd0) begin
                     commit   = 1'b1;
                     state_nx = ST_FIELD;
                  end else begin
                     digit_nx = digit - 2'd1;
                  end
               end else if (u_pos || d_pos) begin
                  case (digit)
                     2'd2:    work_nx[11:8] = stepped;
                     2'd1:    work_nx[7:4]  = stepped;
                     default: work_nx[3:0]  = stepped;
                  endcase
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         field    <= 3'd0;
         digit    <= 2'd2;
         work     <= '0;
         lockout  <= 1'b0;
         cfg_done <= 1'b0;
         set0     <= DEF0;
         set1     <= DEF1;
         set2     <= DEF2;
         set3     <= DEF3;
         setfine  <= DEFF;
      end else begin
         state    <= state_nx;
         field    <= field_nx;
         digit    <= digit_nx;
         work     <= work_nx;
         lockout  <= lock_nx;
         cfg_done <= commit;
         if (commit) begin
            case (field)
               F_SPIN:   set0    <= work;
               F_SMALL:  set1    <= work;
               F_MEDIUM: set2    <= work;
               F_LARGE:  set3    <= work;
               default:  setfine <= work;
            endcase
         end
      end
   end

   // Both the seconds prescaler and the blink phase restart on every pulse,
   // so the timeout is measured from the last press and an edited digit shows at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_cnt   <= '0;
         idle_cnt  <= '0;
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else begin
         if (state == ST_IDLE || any_pulse) begin
            sec_cnt  <= '0;
            idle_cnt <= '0;
         end else if (sec_cnt == 32'(CLK_HZ - 1)) begin
            sec_cnt  <= '0;
            idle_cnt <= idle_cnt + 32'd1;
         end else begin
            sec_cnt <= sec_cnt + 32'd1;
         end
         if (state != ST_EDIT || any_pulse) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
         end else if (blink_cnt == 32'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
         end else begin
            blink_cnt <= blink_cnt + 32'd1;
         end
      end
   end

   always_comb begin
      disp3 = DIG_BLANK;
      disp2 = DIG_BLANK;
      disp1 = DIG_BLANK;
      disp0 = DIG_BLANK;
      case (state)
         ST_FIELD: begin
            disp3 = {1'b0, field};
            disp2 = cur_price[11:8];
            disp1 = cur_price[7:4];
            disp0 = cur_price[3:0];
         end
         ST_EDIT: begin
            disp3 = DIG_E;
            disp2 = work[11:8];
            disp1 = work[7:4];
            disp0 = work[3:0];
            if (blink_off) begin
               case (digit)
                  2'd2:    disp2 = DIG_BLANK;
                  2'd1:    disp1 = DIG_BLANK;
                  default: disp0 = DIG_BLANK;
               endcase
            end
         end
         default: ;
      endcase
   end

endmodule
